seg7_seq_rx: RTL and testbench
==============================

Name: seg7_seq_rx

Overview:
Receive-side counterpart of the up-counter/7-segment display path. Samples an active-low 7-segment pattern stream and filters it for stability. Decodes the pattern back to a BCD digit and checks that accepted digits follow the modulo-10 up-count sequence. Sits on the display bus as a self-check / loopback monitor for counter+encoder blocks in the lab designs.

Parameters:
STABLE_CYC, 1, consecutive identical samples needed before a pattern is accepted (1..15)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
seg_in  in  7  segment pattern, active-low; bit0=a … bit6=g (e.g. 0 = 7'b1000000, 9 = 7'b0010000, blank = 7'b1111111)
digit  out  4  last accepted digit, 0..9
digit_valid  out  1  one-cycle pulse: digit updated
wrap  out  1  one-cycle pulse: accepted 9->0 while locked
seq_err  out  1  one-cycle pulse: accepted digit is not the expected successor
code_err  out  1  one-cycle pulse: accepted pattern is not 0..9 and not blank
locked  out  1  high in S_LOCK
in_err  out  1  high in S_ERR
err_cnt  out  ERR_W  count of seq_err + code_err events, saturating at all-ones

Behaviour:
- Reset (async, active-high): seg_q=7'b1111111, run=0, state=S_IDLE, digit=0, err_cnt=0, all pulses 0, locked=0, in_err=0.
- Sampling: every edge seg_q<=seg_in. If seg_in==seg_q, run<=min(run+1,STABLE_CYC); otherwise run<=1 (a new run starts).
- Accept event: occurs on the edge where a run's length first reaches STABLE_CYC. Each run produces at most one accept event.
  - A pattern that changes every cycle with STABLE_CYC=1 is accepted every cycle.
  - A held pattern is accepted exactly once.
- All outputs are registered and update on the accept edge. Latency from the first sampling edge of a new pattern to its pulse is STABLE_CYC-1 further edges; for STABLE_CYC=1 the pulse appears in the cycle right after the sampling edge.
- Decode: 10 legal digit patterns, plus blank (1111111). Anything else is invalid.
- FSM, evaluated only on accept events; outputs hold otherwise:
  - S_IDLE:
    - digit d: digit<=d, digit_valid, ->S_LOCK
    - blank: stay
    - invalid: code_err, err_cnt++, ->S_ERR
  - S_LOCK, with expected = (digit==9) ? 0 : digit+1:
    - d==expected: digit<=d, digit_valid; wrap if digit==9; stay
    - d!=expected: seq_err, err_cnt++, digit<=d, digit_valid (resync); stay
    - blank: ->S_IDLE, no error
    - invalid: code_err, err_cnt++, ->S_ERR; digit holds
  - S_ERR:
    - digit d: digit<=d, digit_valid, ->S_LOCK (no sequence check)
    - blank: ->S_IDLE
    - invalid: code_err, err_cnt++, stay
- Pulse exclusivity: seq_err and code_err are never asserted together. wrap only coincides with digit_valid.
- err_cnt saturates at 2^ERR_W-1. Pulses still fire when saturated.
- Reset mid-operation clears everything immediately. The first accept after release is evaluated from S_IDLE.
- Illegal state encoding recovers to S_IDLE on the next edge.

Decomposition:
- Package seg7_pkg:
  - state encodings S_IDLE=2'b00, S_LOCK=2'b01, S_ERR=2'b10
  - SEG_0..SEG_9 and SEG_BLANK pattern constants
  - shared with the encoder side so both ends use one table
- Sub-module seg7_decode: combinational pattern -> {is_digit, is_blank, digit[3:0]}. Instantiated once; the stability filter and FSM stay in the top.

Test Plan:
1. Reset, then drive SEG_0..SEG_9, SEG_0 one per cycle (STABLE_CYC=1) -> digit_valid 11 times, digits 0..9,0; wrap once on the 9->0 accept; err_cnt=0; locked=1 after the first accept.
2. STABLE_CYC=3: hold SEG_4 for 5 cycles, then SEG_5 for 2 cycles -> exactly one digit_valid (4), on the 3rd sampling edge; SEG_5 never accepted.
3. Locked at 3, drive SEG_7 -> seq_err pulse, digit=7, err_cnt=1, locked stays 1; then SEG_8 -> clean digit_valid.
4. Drive 7'b0101010 while locked -> code_err, err_cnt+1, in_err=1, digit unchanged; then SEG_2 -> locked=1, digit=2, no seq_err.
5. Drive SEG_BLANK while locked -> locked=0, state S_IDLE, no error; then SEG_6 -> lock on 6 with no seq_err.
6. ERR_W=2: drive 5 invalid patterns -> err_cnt saturates at 3. Then assert rst mid-stream -> all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment tables and receiver types.
// Used by both the encoder side and seg7_seq_rx.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOCK = 2'b01,
      S_ERR  = 2'b10
   } state_t;

   // Active-low patterns, bit0=a .. bit6=g
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef struct packed {
      logic       is_digit;
      logic       is_blank;
      logic [3:0] digit;
   } dec_t;

   function automatic logic [3:0] next_digit(
      input logic [3:0] d
   );
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/seg7_seq_rx_if.sv
// Display bus seen by the sequence monitor.
// slave: seg_in in, results out; master: the reverse.
interface seg7_seq_rx_if #(
   parameter int ERR_W = 8
);

   logic [6:0]       seg_in;
   logic [3:0]       digit;
   logic             digit_valid;
   logic             wrap;
   logic             seq_err;
   logic             code_err;
   logic             locked;
   logic             in_err;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output seg_in,
      input  digit, digit_valid, wrap,
      input  seq_err, code_err,
      input  locked, in_err, err_cnt
   );

   modport slave (
      input  seg_in,
      output digit, digit_valid, wrap,
      output seq_err, code_err,
      output locked, in_err, err_cnt
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational pattern decoder.
// seg -> {is_digit, is_blank, digit}; anything else is invalid.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output dec_t       dec
);

   always_comb begin
      dec = '{is_digit: 1'b0, is_blank: 1'b0, digit: 4'd0};
      unique case (seg)
         SEG_0:     dec = '{1'b1, 1'b0, 4'd0};
         SEG_1:     dec = '{1'b1, 1'b0, 4'd1};
         SEG_2:     dec = '{1'b1, 1'b0, 4'd2};
         SEG_3:     dec = '{1'b1, 1'b0, 4'd3};
         SEG_4:     dec = '{1'b1, 1'b0, 4'd4};
         SEG_5:     dec = '{1'b1, 1'b0, 4'd5};
         SEG_6:     dec = '{1'b1, 1'b0, 4'd6};
         SEG_7:     dec = '{1'b1, 1'b0, 4'd7};
         SEG_8:     dec = '{1'b1, 1'b0, 4'd8};
         SEG_9:     dec = '{1'b1, 1'b0, 4'd9};
         SEG_BLANK: dec = '{1'b0, 1'b1, 4'd0};
         default:   dec = '{1'b0, 1'b0, 4'd0};
      endcase
   end

endmodule

// File: rtl/seg7_seq_rx.sv
// 7-segment loopback monitor: stability filter, decode, mod-10 check.
// Ports: clk, rst (async high), bus (seg_in in; digit/pulses/status out).
module seg7_seq_rx
   import seg7_pkg::*;
#(
   parameter int STABLE_CYC = 1,
   parameter int ERR_W      = 8
) (
   input logic          clk,
   input logic          rst,
   seg7_seq_rx_if.slave bus
);

   localparam logic [3:0] STB = 4'(STABLE_CYC);

   logic [6:0]       seg_q;
   logic [3:0]       run_q, run_d;
   logic             same, accept;
   dec_t             dec;
   logic             bad;

   state_t           state_q, state_d;
   logic [3:0]       digit_q, digit_d;
   logic             dv_q, dv_d;
   logic             wrap_q, wrap_d;
   logic             se_q, se_d;
   logic             ce_q, ce_d;
   logic             inc;
   logic [ERR_W-1:0] err_q, err_d;

   seg7_decode u_dec (
      .seg (bus.seg_in),
      .dec (dec)
   );

   assign bad = !(dec.is_digit || dec.is_blank);

   // Run length saturates at STB; accept only on the
   // edge where it first gets there, so holds fire once.
   always_comb begin
      same  = (bus.seg_in == seg_q);
      run_d = 4'd1;
      if (same)
         run_d = (run_q >= STB) ? STB : run_q + 4'd1;
      accept = (run_d == STB) && !(same && run_q == STB);
   end

   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      dv_d    = 1'b0;
      wrap_d  = 1'b0;
      se_d    = 1'b0;
      ce_d    = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         S_IDLE: if (accept) begin
            unique case (1'b1)
               dec.is_digit: begin
                  digit_d = dec.digit;
                  dv_d    = 1'b1;
                  state_d = S_LOCK;
               end
               dec.is_blank: ;
               bad: begin
                  ce_d    = 1'b1;
                  inc     = 1'b1;
                  state_d = S_ERR;
               end
            endcase
         end
         S_LOCK: if (accept) begin
            unique case (1'b1)
               dec.is_digit: begin
                  digit_d = dec.digit;
                  dv_d    = 1'b1;
                  if (dec.digit == next_digit(digit_q)) begin
                     wrap_d = (digit_q == 4'd9);
                  end else begin
                     se_d = 1'b1;
                     inc  = 1'b1;
                  end
               end
               dec.is_blank: state_d = S_IDLE;
               bad: begin
                  ce_d    = 1'b1;
                  inc     = 1'b1;
                  state_d = S_ERR;
               end
            endcase
         end
         S_ERR: if (accept) begin
            unique case (1'b1)
               dec.is_digit: begin
                  digit_d = dec.digit;
                  dv_d    = 1'b1;
                  state_d = S_LOCK;
               end
               dec.is_blank: state_d = S_IDLE;
               bad: begin
                  ce_d = 1'b1;
                  inc  = 1'b1;
               end
            endcase
         end
         default: state_d = S_IDLE;
      endcase
      err_d = err_q;
      if (inc && err_q != '1)
         err_d = err_q + ERR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q   <= SEG_BLANK;
         run_q   <= 4'd0;
         state_q <= S_IDLE;
         digit_q <= 4'd0;
         dv_q    <= 1'b0;
         wrap_q  <= 1'b0;
         se_q    <= 1'b0;
         ce_q    <= 1'b0;
         err_q   <= '0;
      end else begin
         seg_q   <= bus.seg_in;
         run_q   <= run_d;
         state_q <= state_d;
         digit_q <= digit_d;
         dv_q    <= dv_d;
         wrap_q  <= wrap_d;
         se_q    <= se_d;
         ce_q    <= ce_d;
         err_q   <= err_d;
      end
   end

   assign bus.digit       = digit_q;
   assign bus.digit_valid = dv_q;
   assign bus.wrap        = wrap_q;
   assign bus.seq_err     = se_q;
   assign bus.code_err    = ce_q;
   assign bus.locked      = (state_q == S_LOCK);
   assign bus.in_err      = (state_q == S_ERR);
   assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_seg7_seq_rx.sv
// Bench for seg7_seq_rx: three instances (filter 1/3, narrow counter)
// checked against a sample-level behavioural model.
module tb_seg7_seq_rx;

   typedef struct {
      logic [6:0] prev;
      int         run;
      int         mode;
      int         digit;
      int         errs;
      bit         dv, wr, se, ce;
   } mdl_t;

   localparam logic [6:0] BLK = 7'h7F;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg = 7'h7F;
   logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int         errors = 0;
   int         checks = 0;
   mdl_t       m1, m3, me, m0;

   always #5 clk = ~clk;

   seg7_seq_rx_if #(.ERR_W(8)) b1 ();
   seg7_seq_rx_if #(.ERR_W(8)) b3 ();
   seg7_seq_rx_if #(.ERR_W(2)) be ();

   assign b1.seg_in = seg;
   assign b3.seg_in = seg;
   assign be.seg_in = seg;

   seg7_seq_rx #(.STABLE_CYC(1), .ERR_W(8)) u1 (
      .clk (clk), .rst (rst), .bus (b1));
   seg7_seq_rx #(.STABLE_CYC(3), .ERR_W(8)) u3 (
      .clk (clk), .rst (rst), .bus (b3));
   seg7_seq_rx #(.STABLE_CYC(1), .ERR_W(2)) ue (
      .clk (clk), .rst (rst), .bus (be));

   logic [17:0] v1, v3;
   logic [11:0] ve;
   assign v1 = {b1.digit, b1.digit_valid, b1.wrap, b1.seq_err,
                b1.code_err, b1.locked, b1.in_err, b1.err_cnt};
   assign v3 = {b3.digit, b3.digit_valid, b3.wrap, b3.seq_err,
                b3.code_err, b3.locked, b3.in_err, b3.err_cnt};
   assign ve = {be.digit, be.digit_valid, be.wrap, be.seq_err,
                be.code_err, be.locked, be.in_err, be.err_cnt};

   function automatic int decode(input logic [6:0] s);
      for (int i = 0; i < 10; i++)
         if (s == segs[i]) return i;
      if (s == BLK) return 10;
      return -1;
   endfunction

   // Spec-level model: count consecutive equal samples,
   // act on the sample where the count equals the threshold.
   function automatic mdl_t step(input mdl_t mi, input logic [6:0] s,
                                 input int stable, input int emax);
      mdl_t m = mi;
      int   k;
      bit   err;
      m.dv = 0; m.wr = 0; m.se = 0; m.ce = 0;
      err = 0;
      if (s == m.prev) m.run++;
      else m.run = 1;
      m.prev = s;
      if (m.run == stable) begin
         k = decode(s);
         if (k < 0) begin
            m.ce = 1; err = 1; m.mode = 2;
         end else if (k == 10) begin
            if (m.mode != 0) m.mode = 0;
         end else begin
            if (m.mode == 1) begin
               if (k == (m.digit + 1) % 10) m.wr = (m.digit == 9);
               else begin m.se = 1; err = 1; end
            end
            m.dv = 1; m.digit = k; m.mode = 1;
         end
         if (err && m.errs < emax) m.errs++;
      end
      return m;
   endfunction

   function automatic logic [17:0] pk(input mdl_t m);
      return {4'(m.digit), m.dv, m.wr, m.se, m.ce,
              m.mode == 1, m.mode == 2, 8'(m.errs)};
   endfunction

   function automatic logic [11:0] pke(input mdl_t m);
      return {4'(m.digit), m.dv, m.wr, m.se, m.ce,
              m.mode == 1, m.mode == 2, 2'(m.errs)};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      seg = BLK;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m1 = m0; m3 = m0; me = m0;
   endtask

   task automatic tick(input logic [6:0] s);
      seg = s;
      @(posedge clk);
      m1 = step(m1, s, 1, 255);
      m3 = step(m3, s, 3, 255);
      me = step(me, s, 1, 3);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (v1 !== 18'd0) begin
         errors++;
         $display("FAIL reset_u1 got %h want 0", v1);
      end
      checks++;
      if (v3 !== 18'd0) begin
         errors++;
         $display("FAIL reset_u3 got %h want 0", v3);
      end
      checks++;
      if (ve !== 12'd0) begin
         errors++;
         $display("FAIL reset_ue got %h want 0", ve);
      end
   endtask

   task automatic test_count();
      int ndv = 0, nwr = 0, n3 = 0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         tick(segs[i % 10]);
         ndv += int'(b1.digit_valid);
         nwr += int'(b1.wrap);
         n3  += int'(b3.digit_valid);
         checks++;
         if (v1 !== pk(m1)) begin
            errors++;
            $display("FAIL count_u1 step %0d got %h want %h",
                     i, v1, pk(m1));
         end
         checks++;
         if (b1.locked !== 1'b1 || b1.digit !== 4'(i % 10)) begin
            errors++;
            $display("FAIL count_lock step %0d got %b/%0d want 1/%0d",
                     i, b1.locked, b1.digit, i % 10);
         end
      end
      checks++;
      if (ndv != 11 || nwr != 1 || b1.err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL count_tot got dv=%0d wr=%0d e=%0d want 11/1/0",
                  ndv, nwr, b1.err_cnt);
      end
      checks++;
      if (n3 != 0) begin
         errors++;
         $display("FAIL count_filter3 got %0d want 0", n3);
      end
   endtask

   task automatic test_stable();
      int ndv = 0;
      logic [6:0] pat [7] = '{segs[4], segs[4], segs[4], segs[4],
                              segs[4], segs[5], segs[5]};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         tick(pat[i]);
         ndv += int'(b3.digit_valid);
         checks++;
         if (b3.digit_valid !== (i == 2)) begin
            errors++;
            $display("FAIL stable_dv edge %0d got %b want %b",
                     i, b3.digit_valid, i == 2);
         end
         checks++;
         if (v3 !== pk(m3) || v1 !== pk(m1)) begin
            errors++;
            $display("FAIL stable_mdl edge %0d got %h/%h want %h/%h",
                     i, v3, v1, pk(m3), pk(m1));
         end
      end
      checks++;
      if (ndv != 1 || b3.digit !== 4'd4) begin
         errors++;
         $display("FAIL stable_tot got %0d/%0d want 1/4",
                  ndv, b3.digit);
      end
   endtask

   task automatic test_seq_err();
      do_reset();
      tick(segs[3]);
      tick(segs[7]);
      checks++;
      if (b1.seq_err !== 1'b1 || b1.digit !== 4'd7 ||
          b1.err_cnt !== 8'd1 || b1.locked !== 1'b1 ||
          b1.digit_valid !== 1'b1) begin
         errors++;
         $display("FAIL seq_err got %h want se,7,e1,locked", v1);
      end
      tick(segs[8]);
      checks++;
      if (b1.seq_err !== 1'b0 || b1.digit_valid !== 1'b1 ||
          b1.digit !== 4'd8 || b1.err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL seq_next got %h want clean 8", v1);
      end
   endtask

   task automatic test_code_err();
      do_reset();
      tick(segs[3]);
      tick(7'b0101010);
      checks++;
      if (b1.code_err !== 1'b1 || b1.err_cnt !== 8'd1 ||
          b1.in_err !== 1'b1 || b1.digit !== 4'd3 ||
          b1.locked !== 1'b0 || b1.seq_err !== 1'b0) begin
         errors++;
         $display("FAIL code_err got %h want ce,e1,in_err,3", v1);
      end
      tick(segs[2]);
      checks++;
      if (b1.locked !== 1'b1 || b1.digit !== 4'd2 ||
          b1.seq_err !== 1'b0 || b1.in_err !== 1'b0) begin
         errors++;
         $display("FAIL code_resync got %h want locked 2", v1);
      end
   endtask

   task automatic test_blank();
      do_reset();
      tick(segs[5]);
      tick(BLK);
      checks++;
      if (b1.locked !== 1'b0 || b1.in_err !== 1'b0 ||
          b1.seq_err !== 1'b0 || b1.code_err !== 1'b0 ||
          b1.err_cnt !== 8'd0 || b1.digit !== 4'd5) begin
         errors++;
         $display("FAIL blank got %h want idle 5", v1);
      end
      tick(segs[6]);
      checks++;
      if (b1.locked !== 1'b1 || b1.digit !== 4'd6 ||
          b1.seq_err !== 1'b0 || b1.digit_valid !== 1'b1) begin
         errors++;
         $display("FAIL blank_relock got %h want locked 6", v1);
      end
   endtask

   task automatic test_saturate();
      logic [6:0] bad [5] = '{7'h2A, 7'h55, 7'h7E, 7'h01, 7'h3F};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick(bad[i]);
         checks++;
         if (be.code_err !== 1'b1 || ve !== pke(me)) begin
            errors++;
            $display("FAIL sat_step %0d got %h want %h",
                     i, ve, pke(me));
         end
      end
      checks++;
      if (be.err_cnt !== 2'd3 || b1.err_cnt !== 8'd5) begin
         errors++;
         $display("FAIL sat_cnt got %0d/%0d want 3/5",
                  be.err_cnt, b1.err_cnt);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ve !== 12'd0 || v1 !== 18'd0) begin
         errors++;
         $display("FAIL async_rst got %h/%h want 0/0", ve, v1);
      end
      @(negedge clk);
      rst = 1'b0;
      m1 = m0; m3 = m0; me = m0;
   endtask

   task automatic test_random();
      int nxt = 0;
      int hold;
      logic [6:0] p;
      do_reset();
      for (int n = 0; n < 120; n++) begin
         case ($urandom_range(9))
            0:       p = BLK;
            1:       p = 7'($urandom);
            2, 3:    p = segs[$urandom_range(9)];
            default: begin p = segs[nxt]; nxt = (nxt + 1) % 10; end
         endcase
         hold = int'($urandom_range(4, 1));
         for (int h = 0; h < hold; h++) begin
            tick(p);
            checks++;
            if (v1 !== pk(m1) || v3 !== pk(m3) || ve !== pke(me)) begin
               errors++;
               $display("FAIL rand %0d got %h %h %h want %h %h %h",
                        n, v1, v3, ve, pk(m1), pk(m3), pke(me));
            end
         end
      end
   endtask

   initial begin
      m0 = '{prev: BLK, run: 0, mode: 0, digit: 0, errs: 0,
             dv: 0, wr: 0, se: 0, ce: 0};
      test_reset();
      test_count();
      test_stable();
      test_seq_err();
      test_code_err();
      test_blank();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
